pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32: width of every address and data port.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset.
REQ-003 Parameter IALIGN, default 4 (legal values 2 and 4): instruction alignment in bytes.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port stall, input, 1 bit: holds the PC this cycle.
REQ-007 Port br_taken, input, 1 bit: conditional branch resolved as taken.
REQ-008 Port jal, input, 1 bit: JAL redirect.
REQ-009 Port jalr, input, 1 bit: JALR redirect.
REQ-010 Port rs1, input, XLEN bits: JALR base register value.
REQ-011 Port imm, input, XLEN bits: sign-extended offset for branch, JAL and JALR.
REQ-012 Port trap, input, 1 bit: trap entry request.
REQ-013 Port trap_vec, input, XLEN bits: trap handler address.
REQ-014 Port mret, input, 1 bit: trap return request.
REQ-015 Port mepc, input, XLEN bits: trap return address.
REQ-016 Port pc, output, XLEN bits: current fetch address (registered).
REQ-017 Port pc_plus, output, XLEN bits: pc + 4 (link value), combinational.
REQ-018 Port pc_valid, output, 1 bit: pc is a fetchable address this cycle.
REQ-019 Port fault, output, 1 bit: misaligned-target fault pending.
REQ-020 Port fault_addr, output, XLEN bits: offending target address, registered.

Function
REQ-021 Base select shall be rs1 when jalr=1, else pc; target = base + imm, modulo 2^XLEN, with bit 0 forced to 0 when jalr=1.
REQ-022 The FSM shall have three states: BOOT, RUN and FAULT.
REQ-023 BOOT shall last exactly one cycle after rst_n deasserts, with pc=RESET_VECTOR and pc_valid=0, then go to RUN.
REQ-024 In RUN, the next-PC priority shall be trap > mret > stall > (jal|jalr|br_taken) > pc+4.
REQ-025 trap shall load trap_vec; mret shall load mepc with bit 0 cleared.
REQ-026 stall without trap or mret shall hold pc unchanged; a redirect presented under stall shall be dropped.
REQ-027 A target is misaligned if target[1] is 1 (IALIGN=4) or target[0] is 1 (IALIGN=2, non-JALR); mepc and trap_vec are never checked.
REQ-028 A misaligned redirect shall hold pc, latch the target into fault_addr, set fault=1 and enter FAULT on the next edge.
REQ-029 In FAULT, pc_valid=0 and pc is held; all inputs except trap shall be ignored.
REQ-030 trap in FAULT shall load trap_vec, clear fault and return to RUN in one cycle.
REQ-031 pc_valid shall be 1 only in RUN.
REQ-032 Sequential increment shall wrap from 2^XLEN-4 to 0 with no fault.
REQ-033 Simultaneous jal, jalr and br_taken are illegal; jalr shall take precedence for base select.

Reset
REQ-034 rst_n=0 shall immediately force pc=RESET_VECTOR, fault=0, fault_addr=0, pc_valid=0 and state=BOOT, regardless of clk.
REQ-035 Reset asserted mid-FAULT or mid-stall shall discard all pending state.

Verification
REQ-036 Release reset, no controls -> pc reads 0x0 for two cycles (BOOT, then first RUN), then 0x4, 0x8; pc_valid goes high in the cycle after BOOT.
REQ-037 pc=0x100, br_taken=1, imm=0xFFFF_FFF0 -> next pc=0xF0; with stall=1 as well -> pc stays 0x100.
REQ-038 jalr=1, rs1=0x2003, imm=0x1 -> next pc=0x2004; rs1=0x2001, imm=0x1 (IALIGN=4) -> fault=1, fault_addr=0x2002, pc held, pc_valid=0.
REQ-039 In FAULT, apply jal then trap with trap_vec=0x80 -> jal is ignored; trap gives pc=0x80, fault=0, pc_valid=1.
REQ-040 trap and mret in the same cycle, trap_vec=0x80, mepc=0x401 -> pc=0x80; mret alone -> pc=0x400.
REQ-041 pc=0xFFFF_FFFC, no controls -> pc=0x0 with no fault; rst_n pulsed low asynchronously mid-cycle -> pc is 0x0 immediately.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-PC control bundle: redirect/trap controls toward the sequencer, fetch address and fault status back.
// The master drives the controls; the slave (the sequencer) drives pc/pc_plus/pc_valid/fault/fault_addr.
interface pc_sequencer_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            br_taken;
    logic            jal;
    logic            jalr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] imm;
    logic            trap;
    logic [XLEN-1:0] trap_vec;
    logic            mret;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus;
    logic            pc_valid;
    logic            fault;
    logic [XLEN-1:0] fault_addr;

    modport master (
        output stall, br_taken, jal, jalr, rs1, imm, trap, trap_vec, mret, mepc,
        input  pc, pc_plus, pc_valid, fault, fault_addr
    );

    modport slave (
        input  stall, br_taken, jal, jalr, rs1, imm, trap, trap_vec, mret, mepc,
        output pc, pc_plus, pc_valid, fault, fault_addr
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: one-cycle next-PC update with trap > mret > stall > redirect > +4 priority.
// stall holds the PC and drops any redirect; a misaligned redirect parks the PC in FAULT until trap.
module pc_sequencer #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                IALIGN       = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state_q, state_nx;
    logic [XLEN-1:0] pc_q, pc_nx;
    logic            fault_q, fault_nx;
    logic [XLEN-1:0] faddr_q, faddr_nx;

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] seq_pc;
    logic            redirect;
    logic            misaligned;

    always_comb begin
        base       = bus.jalr ? bus.rs1 : pc_q;
        sum        = base + bus.imm;
        target     = {sum[XLEN-1:1], sum[0] & ~bus.jalr};
        seq_pc     = pc_q + XLEN'(4);
        redirect   = bus.jal | bus.jalr | bus.br_taken;
        // JALR already clears bit 0, so only bit 1 matters for 4-byte alignment
        if (IALIGN == 2) begin
            misaligned = target[0] & ~bus.jalr;
        end else begin
            misaligned = target[1];
        end
    end

    always_comb begin
        state_nx = state_q;
        pc_nx    = pc_q;
        fault_nx = fault_q;
        faddr_nx = faddr_q;
        case (state_q)
            BOOT: begin
                state_nx = RUN;
            end
            RUN: begin
                if (bus.trap) begin
                    pc_nx = bus.trap_vec;
                end else if (bus.mret) begin
                    pc_nx = bus.mepc & ~XLEN'(1);
                end else if (bus.stall) begin
                    pc_nx = pc_q;
                end else if (redirect) begin
                    if (misaligned) begin
                        faddr_nx = target;
                        fault_nx = 1'b1;
                        state_nx = FAULT;
                    end else begin
                        pc_nx = target;
                    end
                end else begin
                    pc_nx = seq_pc;
                end
            end
            FAULT: begin
                if (bus.trap) begin
                    pc_nx    = bus.trap_vec;
                    fault_nx = 1'b0;
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = BOOT;
                pc_nx    = RESET_VECTOR;
                fault_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
            faddr_q <= '0;
        end else begin
            state_q <= state_nx;
            pc_q    <= pc_nx;
            fault_q <= fault_nx;
            faddr_q <= faddr_nx;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pc_plus    = seq_pc;
    assign bus.pc_valid   = (state_q == RUN);
    assign bus.fault      = fault_q;
    assign bus.fault_addr = faddr_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: vector table driven through a scoreboard queue, plus async-reset sequences.
module tb_pc_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_sequencer_if #(.XLEN(32)) bus ();

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .IALIGN       (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ctl;   // {stall, br_taken, jal, jalr, trap, mret}
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] tv;
        logic [31:0] mepc;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_fault;
        logic [31:0] e_faddr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic [5:0] ctl, input logic [31:0] rs1, input logic [31:0] imm,
                                input logic [31:0] tv, input logic [31:0] mepc, input logic [31:0] e_pc,
                                input logic e_valid, input logic e_fault, input logic [31:0] e_faddr);
        vec_t v;
        v.ctl = ctl; v.rs1 = rs1; v.imm = imm; v.tv = tv; v.mepc = mepc;
        v.e_pc = e_pc; v.e_valid = e_valid; v.e_fault = e_fault; v.e_faddr = e_faddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_fault, input logic [31:0] e_faddr);
        chk({tag, ".pc"},         bus.pc,                e_pc);
        chk({tag, ".pc_plus"},    bus.pc_plus,           e_pc + 32'd4);
        chk({tag, ".pc_valid"},   {31'd0, bus.pc_valid}, {31'd0, e_valid});
        chk({tag, ".fault"},      {31'd0, bus.fault},    {31'd0, e_fault});
        chk({tag, ".fault_addr"}, bus.fault_addr,        e_faddr);
    endtask

    task automatic set_idle();
        bus.stall = 1'b0; bus.br_taken = 1'b0; bus.jal = 1'b0; bus.jalr = 1'b0;
        bus.trap = 1'b0; bus.mret = 1'b0;
        bus.rs1 = '0; bus.imm = '0; bus.trap_vec = '0; bus.mepc = '0;
    endtask

    // Present one vector for exactly one rising edge, then score the registered result.
    task automatic drive(input vec_t v, input string tag);
        vec_t e;
        {bus.stall, bus.br_taken, bus.jal, bus.jalr, bus.trap, bus.mret} = v.ctl;
        bus.rs1 = v.rs1; bus.imm = v.imm; bus.trap_vec = v.tv; bus.mepc = v.mepc;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty got 0 entries expected 1", tag);
        end else begin
            e = sb.pop_front();
            chk_state(tag, e.e_pc, e.e_valid, e.e_fault, e.e_faddr);
        end
        set_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        set_idle();
        rst_n = 1'b0;

        vecs.push_back(mk(6'b000000, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 0));
        vecs.push_back(mk(6'b000000, 0, 0, 0, 0, 32'h0000_0004, 1, 0, 0));
        vecs.push_back(mk(6'b000000, 0, 0, 0, 0, 32'h0000_0008, 1, 0, 0));
        vecs.push_back(mk(6'b001000, 0, 32'h0000_00F8, 0, 0, 32'h0000_0100, 1, 0, 0));
        vecs.push_back(mk(6'b110000, 0, 32'hFFFF_FFF0, 0, 0, 32'h0000_0100, 1, 0, 0));
        vecs.push_back(mk(6'b010000, 0, 32'hFFFF_FFF0, 0, 0, 32'h0000_00F0, 1, 0, 0));
        vecs.push_back(mk(6'b000100, 32'h2003, 32'h1, 0, 0, 32'h0000_2004, 1, 0, 0));
        vecs.push_back(mk(6'b000100, 32'h2001, 32'h1, 0, 0, 32'h0000_2004, 0, 1, 32'h2002));
        vecs.push_back(mk(6'b001000, 0, 32'h40, 0, 0, 32'h0000_2004, 0, 1, 32'h2002));
        vecs.push_back(mk(6'b000010, 0, 0, 32'h80, 0, 32'h0000_0080, 1, 0, 32'h2002));
        vecs.push_back(mk(6'b000011, 0, 0, 32'h80, 32'h401, 32'h0000_0080, 1, 0, 32'h2002));
        vecs.push_back(mk(6'b000001, 0, 0, 0, 32'h401, 32'h0000_0400, 1, 0, 32'h2002));
        vecs.push_back(mk(6'b100001, 0, 0, 0, 32'h500, 32'h0000_0500, 1, 0, 32'h2002));
        vecs.push_back(mk(6'b101000, 0, 32'h8, 0, 0, 32'h0000_0500, 1, 0, 32'h2002));
        vecs.push_back(mk(6'b001000, 0, 32'h2, 0, 0, 32'h0000_0500, 0, 1, 32'h502));
        vecs.push_back(mk(6'b100001, 0, 0, 0, 32'h600, 32'h0000_0500, 0, 1, 32'h502));
        vecs.push_back(mk(6'b000010, 0, 0, 32'hFFFF_FFF8, 0, 32'hFFFF_FFF8, 1, 0, 32'h502));
        vecs.push_back(mk(6'b000000, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0, 32'h502));
        vecs.push_back(mk(6'b000000, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 32'h502));
        vecs.push_back(mk(6'b000010, 0, 0, 32'h82, 0, 32'h0000_0082, 1, 0, 32'h502));
        vecs.push_back(mk(6'b000000, 0, 0, 0, 0, 32'h0000_0086, 1, 0, 32'h502));
        vecs.push_back(mk(6'b000100, 32'h11, 32'h1, 0, 0, 32'h0000_0086, 0, 1, 32'h12));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_state("reset", 32'h0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk_state("boot", 32'h0, 1'b0, 1'b0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset in the middle of a cycle while parked in FAULT must clear everything at once.
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_state("boot2", 32'h0, 1'b0, 1'b0, 32'h0);
        drive(mk(6'b000000, 0, 0, 0, 0, 32'h0, 1, 0, 0), "run2_0");
        drive(mk(6'b000000, 0, 0, 0, 0, 32'h4, 1, 0, 0), "run2_1");

        // Reset during a stall: the held PC is discarded.
        bus.stall = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("stall_rst", 32'h0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.stall = 1'b0;
        #1;
        drive(mk(6'b000000, 0, 0, 0, 0, 32'h0, 1, 0, 0), "run3_0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
